// File: rtl/fp_align_pkg.sv
// Shared definitions for the FP alignment stage: default field widths,
// derived widths and field-slice helpers for default-width operands.
package fp_align_pkg;

    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 10;
    localparam int DEF_OP_W  = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int DEF_SIG_W = DEF_MAN_W + 1;

    function automatic logic get_sign(input logic [DEF_OP_W-1:0] op);
        return op[DEF_OP_W-1];
    endfunction

    function automatic logic [DEF_EXP_W-1:0] get_exp(input logic [DEF_OP_W-1:0] op);
        return op[DEF_OP_W-2 -: DEF_EXP_W];
    endfunction

    function automatic logic [DEF_MAN_W-1:0] get_man(input logic [DEF_OP_W-1:0] op);
        return op[DEF_MAN_W-1:0];
    endfunction

    // Denormals (exp field 0) behave as exponent 1 with no hidden bit.
    function automatic logic [DEF_EXP_W-1:0] eff_exp(input logic [DEF_EXP_W-1:0] e);
        return (e == '0) ? {{(DEF_EXP_W-1){1'b0}}, 1'b1} : e;
    endfunction

endpackage

// File: rtl/fp_sticky_shr.sv
// Combinational logical right shift that also reports whether any set bit
// was shifted out. Shift amounts at or beyond the width clear the result.
module fp_sticky_shr
    import fp_align_pkg::*;
#(
    parameter int W    = DEF_MAN_W + 4,
    parameter int SH_W = DEF_EXP_W
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] sh,
    output logic [W-1:0]    dout,
    output logic            sticky
);

    localparam logic [31:0] W_U = W;

    logic [W-1:0] lost_mask;

    // Shift and OR together every bit that falls off the bottom.
    always_comb begin
        dout      = '0;
        sticky    = 1'b0;
        lost_mask = '0;
        if ({{(32-SH_W){1'b0}}, sh} >= W_U) begin
            sticky = |din;
        end else begin
            dout      = din >> sh;
            lost_mask = ~({W{1'b1}} << sh);
            sticky    = |(din & lost_mask);
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage FP operand alignment: S1 picks the larger-magnitude operand and
// the exponent difference, S2 right-shifts the smaller significand with
// guard/round/sticky positions.
// Build option: define ALIGN_STICKY_EN to fold shifted-out bits into the
// sticky bit; otherwise shifted-out bits are simply truncated.
module fp_align_pipe
    import fp_align_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    localparam int OP_W = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_a,
    input  logic [OP_W-1:0]    in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_big_sign,
    output logic               out_small_sign,
    output logic [EXP_W-1:0]   out_big_exp,
    output logic [MAN_W:0]     out_big_man,
    output logic [MAN_W+3:0]   out_small_man,
    output logic [EXP_W-1:0]   out_shift,
    output logic               out_swap
);

    localparam int SIG_W = MAN_W + 1;
    localparam int GRS_W = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
`ifdef ALIGN_STICKY_EN
    localparam logic STICKY_EN = 1'b1;
`else
    localparam logic STICKY_EN = 1'b0;
`endif

    // Handshake: a side transfers on valid && ready. A stage advances when it
    // is empty or its consumer takes its contents this cycle; in_ready is the
    // S1 advance term, so a full pipe accepts and delivers in the same cycle.
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp, a_eff, b_eff;
    logic [SIG_W-1:0] a_sig, b_sig;
    logic             b_big;

    assign a_sign = in_a[OP_W-1];
    assign b_sign = in_b[OP_W-1];
    assign a_exp  = in_a[OP_W-2 -: EXP_W];
    assign b_exp  = in_b[OP_W-2 -: EXP_W];
    assign a_eff  = (a_exp == '0) ? EXP_ONE : a_exp;
    assign b_eff  = (b_exp == '0) ? EXP_ONE : b_exp;
    assign a_sig  = {(a_exp != '0), in_a[MAN_W-1:0]};
    assign b_sig  = {(b_exp != '0), in_b[MAN_W-1:0]};

    // B wins only when strictly larger, so a full tie keeps A as big.
    assign b_big = (b_eff > a_eff) || ((b_eff == a_eff) && (b_sig > a_sig));

    logic             s1_big_sign, s1_small_sign, s1_swap;
    logic [EXP_W-1:0] s1_big_exp, s1_shift;
    logic [SIG_W-1:0] s1_big_sig, s1_small_sig;

    // S1: register the selected operand fields and exponent difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_big_sign   <= 1'b0;
            s1_small_sign <= 1'b0;
            s1_swap       <= 1'b0;
            s1_big_exp    <= '0;
            s1_shift      <= '0;
            s1_big_sig    <= '0;
            s1_small_sig  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_swap       <= b_big;
                s1_big_sign   <= b_big ? b_sign : a_sign;
                s1_small_sign <= b_big ? a_sign : b_sign;
                s1_big_exp    <= b_big ? b_eff : a_eff;
                s1_shift      <= b_big ? (b_eff - a_eff) : (a_eff - b_eff);
                s1_big_sig    <= b_big ? b_sig : a_sig;
                s1_small_sig  <= b_big ? a_sig : b_sig;
            end
        end
    end

    logic [GRS_W-1:0] shr_out;
    logic             shr_sticky;
    logic [GRS_W-1:0] small_aligned;

    fp_sticky_shr #(
        .W    (GRS_W),
        .SH_W (EXP_W)
    ) u_shr (
        .din    ({s1_small_sig, 3'b000}),
        .sh     (s1_shift),
        .dout   (shr_out),
        .sticky (shr_sticky)
    );

    assign small_aligned = {shr_out[GRS_W-1:1], shr_out[0] | (STICKY_EN & shr_sticky)};

    // S2: register the aligned result; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_big_sign   <= 1'b0;
            out_small_sign <= 1'b0;
            out_big_exp    <= '0;
            out_big_man    <= '0;
            out_small_man  <= '0;
            out_shift      <= '0;
            out_swap       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_big_sign   <= s1_big_sign;
                out_small_sign <= s1_small_sign;
                out_big_exp    <= s1_big_exp;
                out_big_man    <= s1_big_sig;
                out_small_man  <= small_aligned;
                out_shift      <= s1_shift;
                out_swap       <= s1_swap;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe with default FP16 widths. Expected
// results are queued when an operand pair is accepted and checked by an
// independent output monitor.
module tb_fp_align_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_big_sign;
    logic        out_small_sign;
    logic [4:0]  out_big_exp;
    logic [10:0] out_big_man;
    logic [13:0] out_small_man;
    logic [4:0]  out_shift;
    logic        out_swap;

    fp_align_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_big_sign   (out_big_sign),
        .out_small_sign (out_small_sign),
        .out_big_exp    (out_big_exp),
        .out_big_man    (out_big_man),
        .out_small_man  (out_small_man),
        .out_shift      (out_shift),
        .out_swap       (out_swap)
    );

`ifdef ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [37:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          received = 0;

    logic [37:0] got;
    assign got = {out_big_sign, out_small_sign, out_big_exp, out_big_man,
                  out_small_man, out_shift, out_swap};

    function automatic logic [37:0] pk(input logic bs, input logic ss,
                                       input logic [4:0] be, input logic [10:0] bm,
                                       input logic [13:0] sm, input logic [4:0] sh,
                                       input logic sw);
        return {bs, ss, be, bm, sm, sh, sw};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    logic [37:0] mon_e;
    string       mon_n;
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            received++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", got);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (got !== mon_e) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", mon_n, got, mon_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the pair is accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [37:0] e, input string nm);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s_accept actual=0 required=1", nm);
        end else begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk({nm, "_idle"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ta[4];
    logic [15:0] tb[4];
    logic [37:0] te[4];

    // ---------------- main sequence ----------------
    initial begin
        int idx;
        int guard;
        bit acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'(got), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: pair presented, result visible two cycles later.
        send(16'h3C00, 16'h3800, pk(0, 0, 5'd15, 11'h400, 14'h1000, 5'd1, 0), "t1_basic");
        @(negedge clk);
        chk("t1_latency_1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_latency_2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain("t1");

        // Back-to-back directed vectors.
        send(16'h3800, 16'h3C00, pk(0, 0, 5'd15, 11'h400, 14'h1000, 5'd1, 1), "t2_swap");
        send(16'h4C00, 16'h3C01, pk(0, 0, 5'd19, 11'h400, STK ? 14'h0201 : 14'h0200, 5'd4, 0), "t3_grs");
        send(16'h7800, 16'h0001, pk(0, 0, 5'd30, 11'h400, STK ? 14'h0001 : 14'h0000, 5'd29, 0), "t4_denorm_far");
        send(16'hBC00, 16'h3C01, pk(0, 1, 5'd15, 11'h401, 14'h2000, 5'd0, 1), "eq_exp_man");
        send(16'h3C00, 16'hBC00, pk(0, 1, 5'd15, 11'h400, 14'h2000, 5'd0, 0), "full_tie");
        send(16'h0001, 16'h0400, pk(0, 0, 5'd1, 11'h400, 14'h0008, 5'd0, 1), "denorm_vs_min");
        send(16'h3C00, 16'h07FF, pk(0, 0, 5'd15, 11'h400, STK ? 14'h0001 : 14'h0000, 5'd14, 0), "shift_eq_width");
        send(16'h3C00, 16'h0800, pk(0, 0, 5'd15, 11'h400, 14'h0001, 5'd13, 0), "shift_width_m1");
        send(16'h3C00, 16'hC800, pk(1, 0, 5'd18, 11'h400, 14'h0400, 5'd3, 1), "neg_big");
        drain("vectors");

        // Stall: out_ready low for 6 cycles while 4 pairs are offered.
        ta[0] = 16'h3C00; tb[0] = 16'h3800; te[0] = pk(0, 0, 5'd15, 11'h400, 14'h1000, 5'd1, 0);
        ta[1] = 16'h3800; tb[1] = 16'h3C00; te[1] = pk(0, 0, 5'd15, 11'h400, 14'h1000, 5'd1, 1);
        ta[2] = 16'h4C00; tb[2] = 16'h3C01; te[2] = pk(0, 0, 5'd19, 11'h400, STK ? 14'h0201 : 14'h0200, 5'd4, 0);
        ta[3] = 16'h3C00; tb[3] = 16'hC800; te[3] = pk(1, 0, 5'd18, 11'h400, 14'h0400, 5'd3, 1);
        received  = 0;
        out_ready = 1'b0;
        idx       = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_a     = ta[idx];
            in_b     = tb[idx];
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                exp_q.push_back(te[idx]);
                name_q.push_back($sformatf("t5_stall_%0d", idx));
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("t5_accepted_while_stalled", 64'(idx), 64'd2);
        chk("t5_in_ready_full", 64'(in_ready), 64'd0);
        chk("t5_stalled_output", 64'(got), 64'(te[0]));
        chk("t5_stalled_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        guard     = 0;
        while (idx < 4 && guard < 50) begin
            in_valid = 1'b1;
            in_a     = ta[idx];
            in_b     = tb[idx];
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                exp_q.push_back(te[idx]);
                name_q.push_back($sformatf("t5_stall_%0d", idx));
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        chk("t5_all_accepted", 64'(idx), 64'd4);
        drain("t5");
        chk("t5_delivered_count", 64'(received), 64'd4);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(16'h3800, 16'h3C00, pk(0, 0, 5'd15, 11'h400, 14'h1000, 5'd1, 1), "t6_lost_0");
        send(16'h4C00, 16'h3C01, pk(0, 0, 5'd19, 11'h400, STK ? 14'h0201 : 14'h0200, 5'd4, 0), "t6_lost_1");
        chk("t6_full_before_reset", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_out_valid", 64'(out_valid), 64'd0);
        chk("t6_async_outputs", 64'(got), 64'd0);
        exp_q.delete();
        name_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(16'h3C00, 16'h3800, pk(0, 0, 5'd15, 11'h400, 14'h1000, 5'd1, 0), "t6_post_reset");
        @(negedge clk);
        chk("t6_latency_1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t6_latency_2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
